fetch_pipeline_ctrl: RTL and testbench

//  Sequencing controller for the MIPS fetch stage. Sits between the debug unit, the ID-stage

---
 rtl/fetch_pipeline_ctrl.sv | 108 ++++++++++
 tb/tb_fetch_pipeline_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_pipeline_ctrl.sv
// Fetch-stage sequencing controller: run/step/halt debug FSM, PC and IF/ID write enables,
// branch/jump redirect selects and a saturating count of executed fetch cycles.
module fetch_pipeline_ctrl #(
   parameter int         NB_BITS     = 32,
   parameter int         NB_CNT      = 32,
   parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_dbg_run,
   input  logic              i_dbg_step,
   input  logic              i_dbg_stop,
   input  logic              i_hzd_stall,
   input  logic              i_id_beq_taken,
   input  logic              i_id_jmp,
   input  logic [NB_BITS-1:0] i_if_id_instr,
   output logic              o_pc_we,
   output logic              o_if_id_we,
   output logic              o_ctr_beq,
   output logic              o_ctr_jmp,
   output logic              o_ctr_flush,
   output logic [1:0]        o_state,
   output logic              o_halted,
   output logic [NB_CNT-1:0] o_cycle_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10,
      ST_HALT = 2'b11
   } state_e;

   state_e            state_q;
   logic [NB_CNT-1:0] cnt_q, cnt_d;

   logic       active;
   logic       halt_det;
   logic       fetch_en;
   logic [5:0] opcode;
   logic       unused_instr_bits;

   assign opcode            = i_if_id_instr[NB_BITS-1 -: 6];
   assign unused_instr_bits = ^i_if_id_instr[NB_BITS-7:0];

   assign active = (state_q == ST_RUN) || (state_q == ST_STEP);

   // A stall holds any redirect until it clears; a jump outranks a taken branch.
   assign o_ctr_jmp   = active & i_id_jmp & ~i_hzd_stall;
   assign o_ctr_beq   = active & i_id_beq_taken & ~i_id_jmp & ~i_hzd_stall;
   assign o_ctr_flush = o_ctr_jmp | o_ctr_beq;

   // A halt opcode sitting in a slot that is being flushed is not a real instruction.
   assign halt_det = active & (opcode == HALT_OPCODE) & ~o_ctr_flush;
   assign fetch_en = active & ~i_hzd_stall & ~halt_det;

   assign o_pc_we     = fetch_en;
   assign o_if_id_we  = fetch_en;
   assign o_state     = state_q;
   assign o_halted    = (state_q == ST_HALT);
   assign o_cycle_cnt = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (fetch_en && (cnt_q != {NB_CNT{1'b1}})) begin
         cnt_d = cnt_q + NB_CNT'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         cnt_q <= cnt_d;
         case (state_q)
            ST_IDLE: begin
               if (i_dbg_stop) begin
                  state_q <= ST_IDLE;
               end else if (i_dbg_step) begin
                  state_q <= ST_STEP;
               end else if (i_dbg_run) begin
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (halt_det) begin
                  state_q <= ST_HALT;
               end else if (i_dbg_stop) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_STEP: begin
               // A step retires only once the single fetch has actually happened.
               if (halt_det) begin
                  state_q <= ST_HALT;
               end else if (!i_hzd_stall || i_dbg_stop) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_HALT;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_pipeline_ctrl.sv
// Scoreboard bench for fetch_pipeline_ctrl: the driver pushes model predictions,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fetch_pipeline_ctrl;

   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   typedef struct packed {
      logic             pc_we;
      logic             if_id_we;
      logic             beq;
      logic             jmp;
      logic             flush;
      logic [1:0]       state;
      logic             halted;
      logic [CNT_W-1:0] cnt;
   } obs_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             dbg_run = 1'b0, dbg_step = 1'b0, dbg_stop = 1'b0;
   logic             hzd_stall = 1'b0, beq_taken = 1'b0, id_jmp = 1'b0;
   logic [31:0]      instr = '0;
   logic             pc_we, if_id_we, ctr_beq, ctr_jmp, ctr_flush, halted;
   logic [1:0]       state;
   logic [CNT_W-1:0] cycle_cnt;

   fetch_pipeline_ctrl #(.NB_BITS(32), .NB_CNT(CNT_W), .HALT_OPCODE(6'b111111)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_dbg_run      (dbg_run),
      .i_dbg_step     (dbg_step),
      .i_dbg_stop     (dbg_stop),
      .i_hzd_stall    (hzd_stall),
      .i_id_beq_taken (beq_taken),
      .i_id_jmp       (id_jmp),
      .i_if_id_instr  (instr),
      .o_pc_we        (pc_we),
      .o_if_id_we     (if_id_we),
      .o_ctr_beq      (ctr_beq),
      .o_ctr_jmp      (ctr_jmp),
      .o_ctr_flush    (ctr_flush),
      .o_state        (state),
      .o_halted       (halted),
      .o_cycle_cnt    (cycle_cnt)
   );

   always #5 clk = ~clk;

   int   checks   = 0;
   int   failures = 0;
   obs_t exp_q[$];
   int   tag_q[$];
   int   cyc_no   = 0;

   // Reference model: mode 0 idle, 1 run, 2 step, 3 halt; executed-fetch count.
   int m_mode = 0;
   int m_cnt  = 0;

   task automatic check(input string name, input obs_t got, input obs_t want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got=%b required=%b (pc_we,if_id_we,beq,jmp,flush,state,halted,cnt)",
                  name, got, want);
      end
   endtask

   task automatic cyc(input logic r, input logic run, input logic step, input logic stop,
                      input logic stall, input logic beq, input logic jmp,
                      input logic [31:0] ins);
      obs_t e;
      bit   act, j, b, f, h, we;
      @(posedge clk);
      #1;
      rst = r; dbg_run = run; dbg_step = step; dbg_stop = stop;
      hzd_stall = stall; beq_taken = beq; id_jmp = jmp; instr = ins;
      if (r) begin
         m_mode = 0;
         m_cnt  = 0;
      end
      act = (m_mode == 1) || (m_mode == 2);
      j   = act && jmp && !stall;
      b   = act && beq && !jmp && !stall;
      f   = j || b;
      h   = act && (ins[31:26] == 6'h3F) && !f;
      we  = act && !stall && !h;
      e.pc_we    = we;
      e.if_id_we = we;
      e.beq      = b;
      e.jmp      = j;
      e.flush    = f;
      e.state    = 2'(m_mode);
      e.halted   = (m_mode == 3);
      e.cnt      = CNT_W'(m_cnt);
      exp_q.push_back(e);
      tag_q.push_back(cyc_no);
      cyc_no++;
      if (!r) begin
         if (we) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
         case (m_mode)
            0: if (!stop) begin
                  if (step) m_mode = 2;
                  else if (run) m_mode = 1;
               end
            1: if (h) m_mode = 3; else if (stop) m_mode = 0;
            2: if (h) m_mode = 3; else if (!stall || stop) m_mode = 0;
            default: m_mode = 3;
         endcase
      end
   endtask

   task automatic idle_cyc(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 32'h0);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         obs_t got;
         int   t;
         got = {pc_we, if_id_we, ctr_beq, ctr_jmp, ctr_flush, state, halted, cycle_cnt};
         t   = tag_q.pop_front();
         check($sformatf("outputs@cycle%0d", t), got, exp_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   localparam logic [31:0] HALT_I = 32'hFC000000;

   initial begin
      cyc(1, 0, 0, 0, 0, 0, 0, 32'h0);
      cyc(1, 0, 0, 0, 0, 0, 0, 32'h0);
      // run for five clean cycles
      cyc(0, 1, 0, 0, 0, 0, 0, 32'h0);
      idle_cyc(5);
      cyc(0, 0, 0, 1, 0, 0, 0, 32'h0);
      idle_cyc(1);
      // single step held off by a two-cycle stall
      cyc(0, 0, 1, 0, 0, 0, 0, 32'h0);
      cyc(0, 0, 0, 0, 1, 0, 0, 32'h0);
      cyc(0, 0, 0, 0, 1, 0, 0, 32'h0);
      idle_cyc(2);
      // redirect priority and stall dominance
      cyc(0, 1, 0, 0, 0, 0, 0, 32'h0);
      cyc(0, 0, 0, 0, 0, 1, 1, 32'h0);
      cyc(0, 0, 0, 0, 1, 1, 1, 32'h0);
      cyc(0, 0, 0, 0, 0, 1, 0, 32'h0);
      cyc(0, 0, 1, 0, 0, 0, 0, 32'h0);
      // halt opcode in a flushed slot does not halt
      cyc(0, 0, 0, 0, 0, 0, 1, HALT_I);
      cyc(0, 0, 0, 0, 0, 1, 0, HALT_I);
      // real halt, then debug pulses are ignored
      cyc(0, 0, 0, 0, 0, 0, 0, HALT_I);
      cyc(0, 1, 0, 0, 0, 0, 0, 32'h0);
      cyc(0, 0, 1, 0, 0, 0, 0, 32'h0);
      cyc(0, 0, 0, 1, 0, 0, 0, 32'h0);
      cyc(1, 0, 0, 0, 0, 0, 0, 32'h0);
      // counter saturation, then reset mid-run
      cyc(0, 1, 0, 0, 0, 0, 0, 32'h0);
      idle_cyc(CNT_MAX + 4);
      cyc(1, 0, 0, 0, 0, 0, 0, 32'h0);
      // halt while stepping, stop during a stalled step
      cyc(0, 0, 1, 0, 0, 0, 0, HALT_I);
      cyc(0, 0, 0, 0, 1, 0, 0, HALT_I);
      cyc(1, 0, 0, 0, 0, 0, 0, 32'h0);
      cyc(0, 0, 1, 0, 1, 0, 0, 32'h0);
      cyc(0, 0, 0, 1, 1, 0, 0, 32'h0);
      idle_cyc(1);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] ins;
         ins = ($urandom_range(0, 19) == 0) ? {6'h3F, 26'($urandom())} : $urandom();
         cyc($urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 5) == 0, ins);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: pending=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
